// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: command codes, controller FSM states and requester IDs shared by spi_ram_ctrl and rr_arb2.
package spi_ram_pkg;
   typedef enum logic [1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD_DATA = 2'b11
   } cmd_e;
   typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT} state_e;
   typedef enum logic {SPI = 1'b0, HOST = 1'b1} req_id_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; the requester not granted last wins a tie.
module rr_arb2
   import spi_ram_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt
);
   req_id_e last_q, last_d;
   always_comb begin
      gnt    = (&req) ? ((last_q == HOST) ? 2'b01 : 2'b10) : req;
      last_d = (en && |req) ? (gnt[1] ? HOST : SPI) : last_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_q <= HOST;
      else     last_q <= last_d;
   end
endmodule

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: SPI command decoder and RAM sequencer shared round-robin with a host port.
// Define SPI_RAM_CTRL_AUTOINC_EN to post-increment wr_addr/rd_addr on accepted data commands.
module spi_ram_ctrl
   import spi_ram_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W+1:0] rx_data,
   input  logic              rx_valid,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              err_ovf
);
   state_e            state_q, state_d;
   req_id_e           owner_q, owner_d;
   logic              pend_v_q, pend_v_d, pend_we_q, pend_we_d;
   logic [ADDR_W-1:0] pend_addr_q, pend_addr_d, wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
   logic [DATA_W-1:0] pend_data_q, pend_data_d;
   logic              err_ovf_q, err_ovf_d;
   logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d, host_gnt_q, host_gnt_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, tx_data_q, tx_data_d, host_rdata_q, host_rdata_d;
   logic              tx_valid_q, tx_valid_d, host_rvalid_q, host_rvalid_d;
   logic [1:0]        gnt;
   logic              idle, go, host_win, spi_win, is_data, accept, ld_wr, ld_rd;
   cmd_e              cmd;
   logic [DATA_W-1:0] payload;

   rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .req ({host_req, pend_v_q}),
      .en  (idle),
      .gnt (gnt)
   );

   always_comb begin
      cmd      = cmd_e'(rx_data[DATA_W+1:DATA_W]);
      payload  = rx_data[DATA_W-1:0];
      idle     = (state_q == IDLE);
      go       = idle && |gnt;
      host_win = go && gnt[1];
      spi_win  = go && gnt[0];
      is_data  = rx_valid && cmd[0];
      accept   = is_data && !pend_v_q;
      ld_wr    = rx_valid && (cmd == CMD_WR_ADDR);
      ld_rd    = rx_valid && (cmd == CMD_RD_ADDR);
      state_d  = idle ? (go ? ACCESS : IDLE) : (state_q == ACCESS && !mem_we_q) ? RD_WAIT : IDLE;
      owner_d  = go ? (host_win ? HOST : SPI) : owner_q;
      // The pending op snapshots its address now, so later address loads cannot retarget it.
      pend_v_d    = accept ? 1'b1 : spi_win ? 1'b0 : pend_v_q;
      pend_we_d   = accept ? (cmd == CMD_WR_DATA) : pend_we_q;
      pend_addr_d = accept ? ((cmd == CMD_WR_DATA) ? wr_addr_q : rd_addr_q) : pend_addr_q;
      pend_data_d = accept ? payload : pend_data_q;
      err_ovf_d   = err_ovf_q | (is_data && pend_v_q);
`ifdef SPI_RAM_CTRL_AUTOINC_EN
      wr_addr_d = ld_wr ? payload : (accept && cmd == CMD_WR_DATA) ? wr_addr_q + 1'b1 : wr_addr_q;
      rd_addr_d = ld_rd ? payload : (accept && cmd == CMD_RD_DATA) ? rd_addr_q + 1'b1 : rd_addr_q;
`else
      wr_addr_d = ld_wr ? payload : wr_addr_q;
      rd_addr_d = ld_rd ? payload : rd_addr_q;
`endif
      mem_en_d      = go;
      mem_we_d      = go && (host_win ? host_we : pend_we_q);
      mem_addr_d    = go ? (host_win ? host_addr : pend_addr_q) : mem_addr_q;
      mem_wdata_d   = go ? (host_win ? host_wdata : pend_data_q) : mem_wdata_q;
      host_gnt_d    = host_win;
      tx_valid_d    = (state_q == RD_WAIT) && (owner_q == SPI);
      host_rvalid_d = (state_q == RD_WAIT) && (owner_q == HOST);
      tx_data_d     = tx_valid_d ? mem_rdata : tx_data_q;
      host_rdata_d  = host_rvalid_d ? mem_rdata : host_rdata_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         owner_q       <= SPI;
         pend_v_q      <= 1'b0;
         pend_we_q     <= 1'b0;
         pend_addr_q   <= '0;
         pend_data_q   <= '0;
         err_ovf_q     <= 1'b0;
         wr_addr_q     <= '0;
         rd_addr_q     <= '0;
         mem_en_q      <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         host_gnt_q    <= 1'b0;
         tx_valid_q    <= 1'b0;
         host_rvalid_q <= 1'b0;
         tx_data_q     <= '0;
         host_rdata_q  <= '0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         pend_v_q      <= pend_v_d;
         pend_we_q     <= pend_we_d;
         pend_addr_q   <= pend_addr_d;
         pend_data_q   <= pend_data_d;
         err_ovf_q     <= err_ovf_d;
         wr_addr_q     <= wr_addr_d;
         rd_addr_q     <= rd_addr_d;
         mem_en_q      <= mem_en_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         host_gnt_q    <= host_gnt_d;
         tx_valid_q    <= tx_valid_d;
         host_rvalid_q <= host_rvalid_d;
         tx_data_q     <= tx_data_d;
         host_rdata_q  <= host_rdata_d;
      end
   end

   assign tx_data     = tx_data_q;
   assign tx_valid    = tx_valid_q;
   assign host_gnt    = host_gnt_q;
   assign host_rvalid = host_rvalid_q;
   assign host_rdata  = host_rdata_q;
   assign mem_en      = mem_en_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign err_ovf     = err_ovf_q;
endmodule
